// File: rtl/alu_result_reg.sv
// alu_result_reg: EX/MEM result register with architectural Z/V/N flags.
// Captures the ALU result, destination index and write request one cycle
// after EX, and updates the flag register from flag-setting opcodes.
// Optional build macro: FLAG_BYPASS_EN
//   defined   -> flag_fwd carries the next-state flags in the same cycle
//                when a flag-setting instruction is being captured
//   undefined -> flag_fwd is the registered flag value only
module alu_result_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              ovfl_in,
    input  logic [3:0]        dst_reg_in,
    input  logic              reg_wr_in,
    output logic [DATA_W-1:0] result_out,
    output logic [3:0]        dst_reg_out,
    output logic              reg_wr_out,
    output logic              valid_out,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic [2:0]        flag_fwd
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;

    logic [DATA_W-1:0] result_d, result_q;
    logic [3:0]        dst_reg_d, dst_reg_q;
    logic              reg_wr_d, reg_wr_q;
    logic              valid_d, valid_q;
    logic              flag_z_d, flag_z_q;
    logic              flag_v_d, flag_v_q;
    logic              flag_n_d, flag_n_q;

    logic cap;
    logic sets_z;
    logic sets_vn;
    logic flag_upd;

    // Opcode decode: which flags the current EX instruction is allowed to write
    always_comb begin
        sets_z  = 1'b0;
        sets_vn = 1'b0;
        case (alu_op)
            OP_ADD, OP_SUB: begin
                sets_z  = 1'b1;
                sets_vn = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: sets_z = 1'b1;
            default: ;
        endcase
        cap      = ~rst & ~flush & ~stall;
        flag_upd = cap & valid_in & (sets_z | sets_vn);
    end

    // Next-state: flush clears the slot, stall holds, otherwise capture
    always_comb begin
        result_d  = result_q;
        dst_reg_d = dst_reg_q;
        reg_wr_d  = reg_wr_q;
        valid_d   = valid_q;
        flag_z_d  = flag_z_q;
        flag_v_d  = flag_v_q;
        flag_n_d  = flag_n_q;
        if (flush) begin
            result_d  = '0;
            dst_reg_d = '0;
            reg_wr_d  = 1'b0;
            valid_d   = 1'b0;
        end else if (cap) begin
            result_d  = alu_out;
            dst_reg_d = dst_reg_in;
            reg_wr_d  = reg_wr_in & valid_in;
            valid_d   = valid_in;
            if (valid_in && sets_z) begin
                flag_z_d = (alu_out == '0);
            end
            if (valid_in && sets_vn) begin
                flag_n_d = alu_out[DATA_W-1];
                flag_v_d = ovfl_in;
            end
        end
    end

    // State register with synchronous reset overriding flush and stall
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            dst_reg_q <= '0;
            reg_wr_q  <= 1'b0;
            valid_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            flag_n_q  <= 1'b0;
        end else begin
            result_q  <= result_d;
            dst_reg_q <= dst_reg_d;
            reg_wr_q  <= reg_wr_d;
            valid_q   <= valid_d;
            flag_z_q  <= flag_z_d;
            flag_v_q  <= flag_v_d;
            flag_n_q  <= flag_n_d;
        end
    end

    assign result_out  = result_q;
    assign dst_reg_out = dst_reg_q;
    assign reg_wr_out  = reg_wr_q;
    assign valid_out   = valid_q;
    assign flag_z      = flag_z_q;
    assign flag_v      = flag_v_q;
    assign flag_n      = flag_n_q;

`ifdef FLAG_BYPASS_EN
    // Branch unit sees the flags the current instruction is about to write
    always_comb begin
        flag_fwd = {flag_z_q, flag_v_q, flag_n_q};
        if (flag_upd) begin
            flag_fwd = {flag_z_d, flag_v_d, flag_n_d};
        end
    end
`else
    // Branch unit sees registered flags only; flag_upd has no consumer here
    always_comb begin
        flag_fwd = {flag_z_q, flag_v_q, flag_n_q};
        if (flag_upd && 1'b0) begin
            flag_fwd = 3'b000;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_reg.sv
// tb_alu_result_reg: directed spec scenarios followed by randomized traffic,
// all outputs compared against a behavioural model of the result register.
module tb_alu_result_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, ovfl_in, reg_wr_in;
    logic [3:0]  alu_op, dst_reg_in;
    logic [15:0] alu_out;
    logic [15:0] result_out;
    logic [3:0]  dst_reg_out;
    logic        reg_wr_out, valid_out, flag_z, flag_v, flag_n;
    logic [2:0]  flag_fwd;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  dst;
        logic        wr;
        logic        vld;
        logic        z;
        logic        v;
        logic        n;
    } st_t;

    st_t mdl;

    alu_result_reg #(.DATA_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .alu_op(alu_op), .alu_out(alu_out),
        .ovfl_in(ovfl_in), .dst_reg_in(dst_reg_in), .reg_wr_in(reg_wr_in),
        .result_out(result_out), .dst_reg_out(dst_reg_out),
        .reg_wr_out(reg_wr_out), .valid_out(valid_out),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .flag_fwd(flag_fwd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: what the register holds after one edge
    function automatic st_t model_next(input st_t s);
        st_t r = s;
        int op = int'(alu_op);
        if (rst) begin
            r = '0;
        end else if (flush) begin
            r.res = 16'h0; r.dst = 4'h0; r.wr = 1'b0; r.vld = 1'b0;
        end else if (!stall) begin
            r.res = alu_out;
            r.dst = dst_reg_in;
            r.vld = valid_in;
            r.wr  = reg_wr_in && valid_in;
            if (valid_in) begin
                if (op == 0 || op == 1 || op == 2 || op == 4 || op == 5 || op == 6)
                    r.z = (alu_out == 16'h0);
                if (op == 0 || op == 1) begin
                    r.n = alu_out[15];
                    r.v = ovfl_in;
                end
            end
        end
        return r;
    endfunction

    task automatic cyc(input logic r, input logic st, input logic fl, input logic vi,
                       input logic [3:0] op, input logic [15:0] ao, input logic ov,
                       input logic [3:0] dst, input logic wr);
        st_t nx;
        logic [2:0] fwd_exp;
        rst = r; stall = st; flush = fl; valid_in = vi; alu_op = op;
        alu_out = ao; ovfl_in = ov; dst_reg_in = dst; reg_wr_in = wr;
        #1;
        nx = model_next(mdl);
`ifdef FLAG_BYPASS_EN
        fwd_exp = (!r && !fl && !st && vi) ? {nx.z, nx.v, nx.n} : {mdl.z, mdl.v, mdl.n};
`else
        fwd_exp = {mdl.z, mdl.v, mdl.n};
`endif
        if (!$isunknown(mdl)) chk("flag_fwd_pre", 32'(flag_fwd), 32'(fwd_exp));
        @(posedge clk);
        #1;
        mdl = nx;
        chk("result_out", 32'(result_out), 32'(mdl.res));
        chk("dst_reg_out", 32'(dst_reg_out), 32'(mdl.dst));
        chk("reg_wr_out", 32'(reg_wr_out), 32'(mdl.wr));
        chk("valid_out", 32'(valid_out), 32'(mdl.vld));
        chk("flags", 32'({flag_z, flag_v, flag_n}), 32'({mdl.z, mdl.v, mdl.n}));
        chk("flag_fwd_post", 32'(flag_fwd), 32'({mdl.z, mdl.v, mdl.n}));
    endtask

    initial begin
        mdl = 'x;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b1; alu_op = 4'h0;
        alu_out = 16'hFFFF; ovfl_in = 1'b1; dst_reg_in = 4'hF; reg_wr_in = 1'b1;
        @(negedge clk);

        // Reset with live inputs for two cycles
        cyc(1, 0, 0, 1, 4'h0, 16'hFFFF, 1, 4'hF, 1);
        cyc(1, 1, 1, 1, 4'h0, 16'hFFFF, 1, 4'hF, 1);
        chk("rst_all_zero", 32'({result_out, dst_reg_out, reg_wr_out, valid_out,
                                 flag_z, flag_v, flag_n}), 32'h0);

        // Set v/n via ADD so SRA holding them is observable
        cyc(0, 0, 0, 1, 4'h0, 16'h8001, 1, 4'h1, 1);
        chk("add_vn", 32'({flag_z, flag_v, flag_n}), 32'b011);
        cyc(0, 0, 0, 1, 4'h5, 16'h0000, 0, 4'h2, 1);
        chk("sra_zero_res", 32'(result_out), 32'h0);
        chk("sra_zero_flags", 32'({flag_z, flag_v, flag_n}), 32'b111);
        cyc(0, 0, 0, 1, 4'h5, 16'hF800, 0, 4'h2, 1);
        chk("sra_nz_flags", 32'({flag_z, flag_v, flag_n}), 32'b011);

        // SUB then PADDSB
        cyc(0, 0, 0, 1, 4'h1, 16'h8000, 1, 4'h4, 1);
        chk("sub_flags", 32'({flag_z, flag_v, flag_n}), 32'b011);
        cyc(0, 0, 0, 1, 4'h7, 16'h0000, 0, 4'h4, 1);
        chk("paddsb_flags", 32'({flag_z, flag_v, flag_n}), 32'b011);

        // Capture, stall three cycles, then stall+flush
        cyc(0, 0, 0, 1, 4'h2, 16'h1234, 0, 4'h3, 1);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 1, 4'h0, 16'h0000, 1, 4'h9, 1);
        chk("stall_hold", 32'({result_out, dst_reg_out}), 32'({16'h1234, 4'h3}));
        cyc(0, 1, 1, 1, 4'h0, 16'h0000, 1, 4'h9, 1);
        chk("stall_flush", 32'({valid_out, reg_wr_out, flag_z}), 32'b000);

        // Bubble
        cyc(0, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h5, 1);
        chk("bubble", 32'({valid_out, reg_wr_out, flag_z}), 32'b000);

        // ADD zero result: forwarding visibility before the edge
        cyc(0, 0, 0, 1, 4'h0, 16'h0000, 0, 4'h6, 1);
        chk("add_zero_z", 32'(flag_fwd[2]), 32'b1);

        // Reset mid-stall, then normal capture
        cyc(0, 1, 0, 1, 4'h0, 16'h5555, 0, 4'h7, 1);
        cyc(1, 1, 0, 1, 4'h0, 16'h5555, 0, 4'h7, 1);
        cyc(0, 0, 0, 1, 4'h1, 16'hABCD, 0, 4'h8, 1);
        chk("post_rst_cap", 32'(result_out), 32'hABCD);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [15:0] ao;
            ao = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom), ao, 1'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_reg.md
ALU_RESULT_REG -- requirements
Module: alu_result_reg

Interface
REQ-001 Parameter: DATA_W, 16, datapath width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 stall  input  1  hold all stage state.
REQ-005 flush  input  1  kill the instruction being captured.
REQ-006 valid_in  input  1  EX-stage instruction valid.
REQ-007 alu_op  input  4  EX opcode: 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0100 SLL, 0101 SRA, 0110 ROR, 0111 PADDSB, 1xxx non-ALU.
REQ-008 alu_out  input  16  ALU result, including the arithmetic shifter output.
REQ-009 ovfl_in  input  1  adder signed-overflow indication for ADD/SUB.
REQ-010 dst_reg_in  input  4  destination register index.
REQ-011 reg_wr_in  input  1  register write request.
REQ-012 result_out  output  16  registered result.
REQ-013 dst_reg_out  output  4  registered destination index.
REQ-014 reg_wr_out  output  1  registered write request, qualified by valid.
REQ-015 valid_out  output  1  registered valid.
REQ-016 flag_z, flag_v, flag_n  output  1 each  architectural flag register.
REQ-017 flag_fwd  output  3  {z,v,n} as seen by the branch unit (see Configuration).

Function
REQ-018 Priority per edge: rst > flush > stall > normal capture.
REQ-019 Capture condition: cap = ~rst & ~flush & ~stall.
REQ-020 On cap: result_out, dst_reg_out and valid_out load alu_out, dst_reg_in and valid_in; reg_wr_out loads reg_wr_in & valid_in.
REQ-021 Latency: exactly one cycle from input to output; no combinational path from alu_out to result_out.
REQ-022 On flush without rst: valid_out=0, reg_wr_out=0, result_out=0, dst_reg_out=0; flags keep their value.
REQ-023 On stall without rst or flush: every register, flags included, holds its value; inputs are ignored.
REQ-024 Flag update requires cap & valid_in; otherwise flags hold.
REQ-025 flag_z loads (alu_out==16'h0000) for ADD, SUB, XOR, SLL, SRA, ROR.
REQ-026 flag_n loads alu_out[15] and flag_v loads ovfl_in, for ADD and SUB only.
REQ-027 RED, PADDSB and 1xxx opcodes leave all flags unchanged.
REQ-028 For SLL/SRA/ROR/XOR, flag_v and flag_n hold.
REQ-029 valid_in=0 on a capture edge produces a bubble: valid_out=0, reg_wr_out=0, result_out=alu_out; flags unchanged.
REQ-030 stall and flush asserted on the same edge: flush behaviour applies.

Reset
REQ-031 rst on an edge sets all outputs to 0 (result_out, dst_reg_out, reg_wr_out, valid_out, flag_z, flag_v, flag_n), overriding stall and flush.
REQ-032 rst mid-stall clears state; the first edge after rst deasserts captures normally.
REQ-033 No asynchronous reset path exists.

Configuration
REQ-034 Macro FLAG_BYPASS_EN.
REQ-035 Defined: flag_fwd is the next-state flag value when cap & valid_in & a flag-setting op is present (same-cycle forwarding); otherwise it equals the registered flags.
REQ-036 Undefined: flag_fwd = {flag_z, flag_v, flag_n}, registered only, with no combinational path from alu_op, alu_out or ovfl_in.

Verification
REQ-037 Reset: rst=1 for 2 cycles with valid_in=1 and alu_out=16'hFFFF -> all outputs 0.
REQ-038 SRA result: op=0101, alu_out=16'h0000, valid_in=1 -> next cycle result_out=0, flag_z=1, v/n unchanged. Then op=0101, alu_out=16'hF800 -> flag_z=0.
REQ-039 SUB: op=0001, alu_out=16'h8000, ovfl_in=1 -> z=0, v=1, n=1. Then PADDSB with alu_out=0 -> flags unchanged.
REQ-040 Stall/flush: capture 16'h1234 dst 3; stall 3 cycles with new inputs -> outputs hold 16'h1234/3. Stall+flush on one edge -> valid_out=0, reg_wr_out=0, flags held.
REQ-041 Bubble: valid_in=0, op=0000, alu_out=0 -> valid_out=0, flag_z unchanged.
REQ-042 Bypass: with FLAG_BYPASS_EN, ADD alu_out=0 -> flag_fwd[2]=1 in the same cycle. Without it, flag_fwd[2]=1 only after the edge.
